// File: rtl/move_scheduler.sv
// Move queue and issue controller: unpacks batches of 4-bit face-turn codes into a FIFO and
// issues them one at a time to the stepper driver. Optional feature macro: MOVE_CANCEL_EN.
module move_scheduler #(
    parameter int DEPTH        = 64,
    parameter int BATCH        = 50,
    parameter int DWELL_CYCLES = 250000
) (
    input  logic                   clock_25mhz,
    input  logic                   reset,
    input  logic [4*BATCH-1:0]     batch_in,
    input  logic                   batch_valid,
    output logic                   batch_ready,
    input  logic                   go,
    input  logic                   pause,
    output logic [3:0]             move_code,
    output logic                   move_start,
    input  logic                   move_done,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   all_done,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(BATCH + 1);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [AW:0]   ZERO_COUNT = (AW+1)'(0);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [IW-1:0] LAST_NIB   = IW'(BATCH - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        DWELL     = 2'd3
    } state_t;

    logic [4*BATCH-1:0] batch_r;
    logic [IW-1:0]      nib_idx_r;
    logic               loading_r;
    logic [3:0]         nib_s;
    logic               nib_valid_s;
    logic               load_last_s;

    logic [3:0]         mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW:0]        count_next_s;
    logic               push_s;
    logic               pop_s;
    logic               cancel_s;
    logic               drop_s;

    state_t             state_r;
    logic               armed_r;
    logic               pause_r;
    logic [DW-1:0]      dwell_cnt_r;
    logic               issue_s;
    logic               drain_s;

    // Current nibble of the batch being unpacked and whether it ends the load.
    always_comb begin
        nib_s       = batch_r[3:0];
        nib_valid_s = loading_r && (nib_s >= 4'd2) && (nib_s <= 4'd13);
        load_last_s = loading_r && ((nib_s == 4'd0) || (nib_idx_r == LAST_NIB));
    end

    // Issue and drain decisions taken in IDLE; the head is popped on the issue decision.
    always_comb begin
        issue_s = (state_r == IDLE) && armed_r && (fifo_count != ZERO_COUNT) && !pause_r;
        drain_s = (state_r == IDLE) && armed_r && (fifo_count == ZERO_COUNT) && batch_ready;
        pop_s   = issue_s;
    end

`ifdef MOVE_CANCEL_EN
    logic [AW-1:0] tail_ptr_s;

    // A move that undoes the newest queued entry removes it, unless that entry is leaving now.
    always_comb begin
        tail_ptr_s = wr_ptr_r - AW'(1);
        cancel_s   = nib_valid_s && (fifo_count != ZERO_COUNT)
                     && !(pop_s && (fifo_count == (AW+1)'(1)))
                     && (mem_r[tail_ptr_s] == (nib_s ^ 4'd1));
    end
`else
    // Cancellation disabled: every valid move is pushed as-is.
    always_comb begin
        cancel_s = 1'b0;
    end
`endif

    // Push/drop decision; a simultaneous pop frees the slot the push needs.
    always_comb begin
        push_s       = nib_valid_s && !cancel_s && ((fifo_count != FULL_COUNT) || pop_s);
        drop_s       = nib_valid_s && !cancel_s && !push_s;
        count_next_s = fifo_count + (AW+1)'(push_s) - (AW+1)'(pop_s) - (AW+1)'(cancel_s);
    end

    // Batch loader: latch a packed word, then walk one nibble per cycle.
    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            batch_r     <= '0;
            nib_idx_r   <= '0;
            loading_r   <= 1'b0;
            batch_ready <= 1'b1;
        end else if (batch_valid && batch_ready) begin
            batch_r     <= batch_in;
            nib_idx_r   <= '0;
            loading_r   <= 1'b1;
            batch_ready <= 1'b0;
        end else if (loading_r) begin
            batch_r   <= batch_r >> 3'd4;
            nib_idx_r <= nib_idx_r + IW'(1);
            if (load_last_s) begin
                loading_r   <= 1'b0;
                batch_ready <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clock_25mhz) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= nib_s;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else if (cancel_s) begin
                wr_ptr_r <= wr_ptr_r - AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            fifo_count <= count_next_s;
            if (drop_s) begin
                overflow <= 1'b1;
            end
        end
    end

    // Issue FSM. pause is registered so a release is evaluated in IDLE the cycle after,
    // matching the go path (strobe, IDLE evaluation, then ISSUE).
    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            state_r     <= IDLE;
            armed_r     <= 1'b0;
            pause_r     <= 1'b0;
            dwell_cnt_r <= '0;
            move_code   <= 4'd0;
            move_start  <= 1'b0;
            busy        <= 1'b0;
            all_done    <= 1'b0;
        end else begin
            pause_r    <= pause;
            move_start <= 1'b0;
            all_done   <= drain_s;
            if (drain_s) begin
                armed_r <= 1'b0;
            end else if (go) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        move_code  <= mem_r[rd_ptr_r];
                        move_start <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_r <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (move_done) begin
                        dwell_cnt_r <= '0;
                        state_r     <= DWELL;
                    end
                end
                DWELL: begin
                    if (dwell_cnt_r == DWELL_LAST) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        dwell_cnt_r <= dwell_cnt_r + DW'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
